// File: rtl/sa_pkg.sv
// Shared definitions for the SA load-protocol driver: state codes, burst
// geometry, legal run lengths and the buffer-select encoding.
package sa_pkg;

   localparam int N     = 8;
   localparam int BURST = 192;

   // Bit t set means T = t is an accepted run length (1, 4 and 8).
   localparam logic [15:0] T_LEGAL = 16'h0112;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SEND    = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_COLLECT = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   typedef enum logic [1:0] {
      SEL_IN = 2'd0,
      SEL_Q  = 2'd1,
      SEL_K  = 2'd2,
      SEL_V  = 2'd3
   } buf_sel_t;

   function automatic logic t_legal(input logic [3:0] t);
      return T_LEGAL[t];
   endfunction

   // Number of results SA returns for a run of length t.
   function automatic logic [6:0] out_len(input logic [3:0] t);
      return 7'(int'(t) * N);
   endfunction

endpackage

// File: rtl/sa_drv_buf.sv
// Four 64-byte matrix buffers with one write port and one row-wide read
// port. A read returns the same address from all four buffers so the SEND
// logic can fetch in_data and w_Q for one column position in one access.
// A write to the address being read is forwarded, so a byte written in the
// launch cycle is already visible to the first burst word.
module sa_drv_buf
   import sa_pkg::*;
(
   input  logic            clk,
   input  logic            wr_en,
   input  logic [1:0]      wr_sel,
   input  logic [5:0]      wr_addr,
   input  logic [7:0]      wr_data,
   input  logic [5:0]      rd_addr,
   output logic [3:0][7:0] rd_row
);

   logic [7:0] mem [4][64];

   // Host write port; contents are deliberately not reset so weights survive.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_sel][wr_addr] <= wr_data;
      end
   end

   // Asynchronous read of all four buffers with write-through forwarding.
   always_comb begin
      for (int s = 0; s < 4; s++) begin
         rd_row[s] = mem[s][rd_addr];
         if (wr_en && wr_sel == 2'(s) && wr_addr == rd_addr) begin
            rd_row[s] = wr_data;
         end
      end
   end

endmodule

// File: rtl/sa_driver.sv
// Host-side driver for the SA engine: buffers four matrices, plays the
// 192-cycle input burst, collects T*8 results and reports a wrapping sum.
module sa_driver
   import sa_pkg::*;
#(
   parameter int TIMEOUT = 1023
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [1:0]  wr_sel,
   input  logic [5:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        start,
   input  logic [3:0]  t_sel,
   output logic        busy,
   output logic        in_valid,
   output logic [3:0]  T,
   output logic [7:0]  in_data,
   output logic [7:0]  w_Q,
   output logic [7:0]  w_K,
   output logic [7:0]  w_V,
   input  logic        out_valid,
   input  logic [63:0] out_data,
   output logic        res_valid,
   output logic [63:0] res_data,
   output logic        res_last,
   output logic        done,
   output logic [63:0] checksum,
   output logic        err
);

   localparam int WW = $clog2(TIMEOUT + 1);

   logic [2:0]      state;
   logic [7:0]      cnt;
   logic [WW-1:0]   wcnt;
   logic [6:0]      n;
   logic [3:0]      t_run;
   logic [63:0]     acc;

   logic            idle_free;
   logic            buf_we;
   logic [7:0]      idx;
   logic [3:0]      t_eff;
   logic [3:0][7:0] row;
   logic [3:0]      nxt_t;
   logic [7:0]      nxt_in;
   logic [7:0]      nxt_q;
   logic [7:0]      nxt_k;
   logic [7:0]      nxt_v;

   // The done cycle already sits in IDLE but still reports busy, so both
   // conditions gate host writes and launches.
   assign idle_free = (state == ST_IDLE) && !busy;
   assign buf_we    = wr_en && idle_free;

   sa_drv_buf u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (idx[5:0]),
      .rd_row  (row)
   );

   // Burst word for position idx: position 0 at launch, the counter during SEND.
   always_comb begin
      idx    = (state == ST_SEND) ? cnt : 8'd0;
      t_eff  = (state == ST_SEND) ? t_run : t_sel;
      nxt_t  = (idx == 8'd0) ? t_eff : 4'd0;
      nxt_in = (idx < 8'd64 && {1'b0, idx[5:3]} < t_eff) ? row[SEL_IN] : 8'd0;
      nxt_q  = (idx < 8'd64) ? row[SEL_Q] : 8'd0;
      nxt_k  = (idx[7:6] == 2'b01) ? row[SEL_K] : 8'd0;
      nxt_v  = (idx[7:6] == 2'b10) ? row[SEL_V] : 8'd0;
   end

   // Run sequencing, burst output registers and result collection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         wcnt      <= '0;
         n         <= '0;
         t_run     <= '0;
         acc       <= '0;
         busy      <= 1'b0;
         in_valid  <= 1'b0;
         T         <= '0;
         in_data   <= '0;
         w_Q       <= '0;
         w_K       <= '0;
         w_V       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_last  <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
         err       <= 1'b0;
      end else begin
         err       <= 1'b0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
         done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (done) begin
                  busy <= 1'b0;
               end
               if (start && idle_free) begin
                  if (t_legal(t_sel)) begin
                     t_run    <= t_sel;
                     acc      <= '0;
                     checksum <= '0;
                     n        <= '0;
                     wcnt     <= '0;
                     busy     <= 1'b1;
                     in_valid <= 1'b1;
                     T        <= nxt_t;
                     in_data  <= nxt_in;
                     w_Q      <= nxt_q;
                     w_K      <= nxt_k;
                     w_V      <= nxt_v;
                     cnt      <= 8'd1;
                     state    <= ST_SEND;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (out_valid) begin
                  err <= 1'b1;
               end
               if (cnt == 8'(BURST)) begin
                  in_valid <= 1'b0;
                  T        <= '0;
                  in_data  <= '0;
                  w_Q      <= '0;
                  w_K      <= '0;
                  w_V      <= '0;
                  wcnt     <= '0;
                  state    <= ST_WAIT;
               end else begin
                  T       <= nxt_t;
                  in_data <= nxt_in;
                  w_Q     <= nxt_q;
                  w_K     <= nxt_k;
                  w_V     <= nxt_v;
                  cnt     <= cnt + 8'd1;
               end
            end
            ST_WAIT: begin
               if (out_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= out_data;
                  acc       <= acc + out_data;
                  n         <= 7'd1;
                  state     <= ST_COLLECT;
               end else if (wcnt == WW'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            ST_COLLECT: begin
               if (out_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= out_data;
                  acc       <= acc + out_data;
                  n         <= n + 7'd1;
                  if (n + 7'd1 == out_len(t_run)) begin
                     res_last <= 1'b1;
                     state    <= ST_DONE;
                  end
               end else begin
                  err   <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done     <= 1'b1;
               checksum <= acc;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sa_driver.sv
// Directed bench for sa_driver: a buffer model predicts every burst word
// each cycle, and run tasks check forwarded results, done and checksum.
module tb_sa_driver;
   import sa_pkg::*;

   localparam int TO = 1023;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_sel = '0;
   logic [5:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        start = 1'b0;
   logic [3:0]  t_sel = '0;
   logic        busy;
   logic        in_valid;
   logic [3:0]  T;
   logic [7:0]  in_data;
   logic [7:0]  w_Q;
   logic [7:0]  w_K;
   logic [7:0]  w_V;
   logic        out_valid = 1'b0;
   logic [63:0] out_data = '0;
   logic        res_valid;
   logic [63:0] res_data;
   logic        res_last;
   logic        done;
   logic [63:0] checksum;
   logic        err;

   int          edges = 0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mbuf [4][64];
   logic        send_on = 1'b0;
   int          send_start = 0;
   int          send_t = 0;
   logic        cmp_en = 1'b0;
   logic [63:0] reply [64];
   logic [36:0] exp_s;

   sa_driver #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .t_sel     (t_sel),
      .busy      (busy),
      .in_valid  (in_valid),
      .T         (T),
      .in_data   (in_data),
      .w_Q       (w_Q),
      .w_K       (w_K),
      .w_V       (w_V),
      .out_valid (out_valid),
      .out_data  (out_data),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_last  (res_last),
      .done      (done),
      .checksum  (checksum),
      .err       (err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count rising edges so burst positions can be derived from launch time.
   always @(posedge clk) edges <= edges + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected {in_valid, T, in_data, w_Q, w_K, w_V} for burst position c.
   function automatic logic [36:0] exp_stream(input int c, input int t);
      logic [3:0] tt;
      logic [7:0] a, q, k, v;
      if (c < 0 || c >= 192) return '0;
      tt = (c == 0) ? 4'(t) : 4'd0;
      a  = (c < 64 && (c / 8) < t) ? mbuf[0][c] : 8'd0;
      q  = (c < 64) ? mbuf[1][c] : 8'd0;
      k  = (c >= 64 && c < 128) ? mbuf[2][c-64] : 8'd0;
      v  = (c >= 128) ? mbuf[3][c-128] : 8'd0;
      return {1'b1, tt, a, q, k, v};
   endfunction

   // Every cycle, compare the SA-side outputs with the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         exp_s = send_on ? exp_stream(edges - send_start, send_t) : '0;
         check_output("sa_stream", {27'd0, in_valid, T, in_data, w_Q, w_K, w_V}, {27'd0, exp_s});
      end
   end

   task automatic check_all_zero(input string tag);
      check_output({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check_output({tag, "_sa"}, {27'd0, in_valid, T, in_data, w_Q, w_K, w_V}, 64'd0);
      check_output({tag, "_res"}, {62'd0, res_valid, res_last}, 64'd0);
      check_output({tag, "_res_data"}, res_data, 64'd0);
      check_output({tag, "_done_err"}, {62'd0, done, err}, 64'd0);
      check_output({tag, "_checksum"}, checksum, 64'd0);
   endtask

   task automatic load_all();
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_sel  = 2'(s);
            wr_addr = 6'(i);
            wr_data = 8'(i - 32);
            mbuf[s][i] = 8'(i - 32);
         end
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Pulse start (optionally with a same-cycle write); returns at burst position 0.
   task automatic launch(input int t, input logic do_wr, input int sel, input int addr, input logic [7:0] data);
      @(negedge clk);
      start = 1'b1;
      t_sel = 4'(t);
      if (do_wr) begin
         wr_en   = 1'b1;
         wr_sel  = 2'(sel);
         wr_addr = 6'(addr);
         wr_data = data;
         mbuf[sel][addr] = data;
      end
      if (t == 1 || t == 4 || t == 8) begin
         send_on    = 1'b1;
         send_start = edges + 1;
         send_t     = t;
      end
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic wait_c(input int target);
      while (edges - send_start < target) @(negedge clk);
   endtask

   // Play cnt SA results from reply[], expecting a run of len results.
   task automatic run_results(input int cnt, input int len, input logic [63:0] lit);
      logic [63:0] sum;
      logic        last_exp;
      sum = '0;
      for (int i = 0; i < cnt; i++) sum += reply[i];
      @(negedge clk);
      out_valid = 1'b1;
      out_data  = reply[0];
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk);
         last_exp = (i == cnt - 1) && (cnt == len);
         check_output("res_valid", {63'd0, res_valid}, 64'd1);
         check_output("res_data", res_data, reply[i]);
         check_output("res_last", {63'd0, res_last}, {63'd0, last_exp});
         if (i + 1 < cnt) begin
            out_data = reply[i+1];
         end else begin
            out_valid = 1'b0;
            out_data  = '0;
         end
      end
      if (cnt < len) begin
         @(negedge clk);
         check_output("short_err", {63'd0, err}, 64'd1);
      end
      @(negedge clk);
      check_output("done", {63'd0, done}, 64'd1);
      check_output("done_busy", {63'd0, busy}, 64'd1);
      check_output("checksum_model", checksum, sum);
      check_output("checksum_literal", checksum, lit);
      @(negedge clk);
      check_output("after_done", {62'd0, busy, done}, 64'd0);
   endtask

   // Abort if anything stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int found;

      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      $display("[TB] loading buffers");
      load_all();

      $display("[TB] run T=8");
      launch(8, 1'b0, 0, 0, 8'd0);
      check_output("T_first", {60'd0, T}, 64'd8);
      wait_c(10);
      start = 1'b1;
      t_sel = 4'd1;
      @(negedge clk);
      start = 1'b0;
      wait_c(64);
      check_output("wK_c64", {56'd0, w_K}, 64'hE0);
      wait_c(193);
      wr_en   = 1'b1;
      wr_sel  = 2'd0;
      wr_addr = 6'd5;
      wr_data = 8'h55;
      @(negedge clk);
      wr_en = 1'b0;
      for (int i = 0; i < 64; i++) reply[i] = 64'd1;
      run_results(64, 64, 64'd64);

      $display("[TB] run T=1");
      launch(1, 1'b0, 0, 0, 8'd0);
      wait_c(7);
      check_output("in_c7", {56'd0, in_data}, 64'hE7);
      @(negedge clk);
      check_output("in_c8", {56'd0, in_data}, 64'd0);
      wait_c(195);
      for (int i = 0; i < 8; i++) reply[i] = -64'sd5;
      run_results(8, 8, 64'hFFFF_FFFF_FFFF_FFD8);

      $display("[TB] run T=4 with write at launch");
      launch(4, 1'b1, 1, 0, 8'h11);
      check_output("wQ_fwd", {56'd0, w_Q}, 64'h11);
      wait_c(194);
      reply[0] = 64'h7FFF_FFFF_FFFF_FFFF;
      reply[1] = 64'd1;
      for (int i = 2; i < 32; i++) reply[i] = 64'd0;
      run_results(32, 32, 64'h8000_0000_0000_0000);

      $display("[TB] illegal T");
      @(negedge clk);
      start = 1'b1;
      t_sel = 4'd3;
      @(negedge clk);
      start = 1'b0;
      check_output("illegal_err", {63'd0, err}, 64'd1);
      check_output("illegal_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check_output("illegal_err_pulse", {63'd0, err}, 64'd0);

      $display("[TB] timeout");
      launch(1, 1'b0, 0, 0, 8'd0);
      wait_c(192);
      found = -1;
      for (int i = 0; i < TO + 80; i++) begin
         if (err) begin
            found = i;
            break;
         end
         @(negedge clk);
      end
      check_output("timeout_cycle", 64'(found), 64'(TO));
      @(negedge clk);
      check_output("timeout_done", {63'd0, done}, 64'd1);
      check_output("timeout_checksum", checksum, 64'd0);
      @(negedge clk);
      check_output("timeout_idle", {63'd0, busy}, 64'd0);

      $display("[TB] short result burst");
      launch(4, 1'b0, 0, 0, 8'd0);
      wait_c(195);
      for (int i = 0; i < 5; i++) reply[i] = 64'(i + 1);
      run_results(5, 32, 64'd15);

      $display("[TB] reset mid-run and rerun");
      launch(8, 1'b0, 0, 0, 8'd0);
      wait_c(100);
      #2;
      cmp_en  = 1'b0;
      rst_n   = 1'b0;
      send_on = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;
      launch(8, 1'b0, 0, 0, 8'd0);
      wait_c(194);
      for (int i = 0; i < 64; i++) reply[i] = 64'd1;
      run_results(64, 64, 64'd64);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
